// File: rtl/vjtag_dr_bridge.sv
// Virtual JTAG data-register bridge: serial DR shifting into a buffered write FIFO.
// Optional macro VJTAG_READBACK_EN: READ captures rd_data into sr instead of using bypass.
module vjtag_dr_bridge #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              tck,
  input  logic              rst,
  input  logic              tdi,
  output logic              tdo,
  input  logic              ir_in,
  output logic              ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_e1dr,
  input  logic              virtual_state_pdr,
  input  logic              virtual_state_e2dr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_cir,
  input  logic              virtual_state_uir,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              overflow
);

  typedef enum logic {IR_READ = 1'b0, IR_WRITE = 1'b1} ir_e;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] sr, sr_nxt;
  logic              byp, byp_nxt;
  logic              is_write, sel_sr;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop, drop, upd_write;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  // Pause/exit states and Capture-IR simply leave everything holding.
  logic unused_states;
  assign unused_states = virtual_state_e1dr | virtual_state_pdr |
                         virtual_state_e2dr | virtual_state_cir;

  assign is_write = (ir_e'(ir_in) == IR_WRITE);

`ifdef VJTAG_READBACK_EN
  assign sel_sr = 1'b1;
`else
  assign sel_sr = is_write;
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  assign tdo    = sel_sr ? sr[0] : byp;
  assign ir_out = overflow;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sr_nxt  = sr;
    byp_nxt = byp;
    if (virtual_state_cdr) begin
      if (is_write) begin
        sr_nxt = '0;
      end else begin
`ifdef VJTAG_READBACK_EN
        sr_nxt = rd_data;
`else
        byp_nxt = 1'b0;
`endif
      end
    end else if (virtual_state_sdr) begin
      if (sel_sr) sr_nxt  = {tdi, sr[DATA_W-1:1]};
      else        byp_nxt = tdi;
    end
  end

  assign wr_valid  = (count != '0);
  assign wr_data   = mem[rd_ptr];
  assign pop       = wr_valid & wr_ready;
  assign upd_write = virtual_state_udr & is_write;
  // A full FIFO still accepts the word when the consumer frees a slot this cycle.
  assign push      = upd_write & ((count < DEPTH_C) | pop);
  assign drop      = upd_write & ~push;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      byp      <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      sr  <= sr_nxt;
      byp <= byp_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (drop)                   overflow <= 1'b1;
      else if (virtual_state_uir) overflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; count gates wr_valid, so stale entries are never consumed.
  always_ff @(posedge tck) begin
    if (push) mem[wr_ptr] <= sr;
  end

endmodule

// File: tb/tb_vjtag_dr_bridge.sv
// Scoreboard bench for vjtag_dr_bridge: expected words queued at Update-DR, popped on drain.
module tb_vjtag_dr_bridge;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          tck = 1'b0;
  logic          rst = 1'b1;
  logic          tdi = 1'b0;
  logic          ir_in = 1'b0;
  logic          cdr = 1'b0, sdr = 1'b0, e1dr = 1'b0, pdr = 1'b0;
  logic          e2dr = 1'b0, udr = 1'b0, cir = 1'b0, uir = 1'b0;
  logic          wr_ready = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          tdo, ir_out, wr_valid, overflow;
  logic [DW-1:0] wr_data;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_ovf = 1'b0;

  vjtag_dr_bridge #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .tck(tck), .rst(rst), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_e1dr(e1dr),
    .virtual_state_pdr(pdr), .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
    .virtual_state_cir(cir), .virtual_state_uir(uir),
    .rd_data(rd_data), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .overflow(overflow)
  );

  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic clr_states();
    cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
  endtask

  // Full WRITE DR scan with a pause mid-shift; optionally pops on the Update-DR cycle.
  task automatic do_write(input logic [DW-1:0] w, input bit pop_on_upd);
    logic [DW-1:0] exp;
    ir_in = 1'b1;
    clr_states();
    cdr = 1; tick(); cdr = 0;
    for (int i = 0; i < DW; i++) begin
      if (i == 16) begin
        sdr = 0; e1dr = 1; tick(); e1dr = 0;
        pdr = 1; tick(); tick(); pdr = 0;
        e2dr = 1; tdi = ~tdi; tick(); e2dr = 0;
      end
      sdr = 1; tdi = w[i]; tick();
    end
    sdr = 0; e1dr = 1; tick(); e1dr = 0;
    udr = 1;
    if (pop_on_upd) begin
      wr_ready = 1'b1;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      vectors++;
      if (wr_valid !== 1'b1 || wr_data !== exp) begin
        miscompares++;
        $display("FAIL upd_pop: got valid=%b data=%h, want valid=1 data=%h", wr_valid, wr_data, exp);
      end
    end
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else exp_ovf = 1'b1;
    tick();
    udr = 0; wr_ready = 1'b0; tdi = 1'b0;
    vectors++;
    if (overflow !== exp_ovf || ir_out !== exp_ovf) begin
      miscompares++;
      $display("FAIL ovf_after_upd(%h): got overflow=%b ir_out=%b, want %b", w, overflow, ir_out, exp_ovf);
    end
  endtask

  task automatic drain(input string tag);
    logic [DW-1:0] exp;
    wr_ready = 1'b1;
    for (int n = 0; n < 16 && wr_valid === 1'b1; n++) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s_extra: got unexpected word %h, want none", tag, wr_data);
      end else begin
        exp = exp_q.pop_front();
        if (wr_data !== exp) begin
          miscompares++;
          $display("FAIL %s_word: got %h, want %h", tag, wr_data, exp);
        end
      end
      tick();
    end
    wr_ready = 1'b0;
    vectors++;
    if (wr_valid !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_end: got wr_valid=%b with %0d words outstanding, want 0 and 0",
               tag, wr_valid, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (tdo !== 1'b0 || wr_valid !== 1'b0 || overflow !== 1'b0 || ir_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got tdo=%b wr_valid=%b overflow=%b ir_out=%b, want all 0",
               tdo, wr_valid, overflow, ir_out);
    end
    @(negedge tck);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_write(32'hDEADBEEF, 1'b0);
    vectors++;
    if (wr_valid !== 1'b1 || wr_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_latency: got valid=%b data=%h, want valid=1 data=deadbeef", wr_valid, wr_data);
    end
    drain("single");
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 5; v++) do_write(DW'(v), 1'b0);
    vectors++;
    if (overflow !== 1'b1 || ir_out !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flag: got overflow=%b ir_out=%b, want 1 1", overflow, ir_out);
    end
    drain("overflow");
  endtask

  task automatic test_uir();
    uir = 1; tick(); uir = 0;
    exp_ovf = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || ir_out !== 1'b0) begin
      miscompares++;
      $display("FAIL uir_clear: got overflow=%b ir_out=%b, want 0 0", overflow, ir_out);
    end
  endtask

  task automatic test_full_pop();
    for (int v = 0; v < DEPTH; v++) do_write(32'hC0DE0010 + DW'(v), 1'b0);
    do_write(32'hC0DE0014, 1'b1);
    drain("full_pop");
  endtask

  task automatic test_readback();
    logic prev;
    logic first_b;
    logic b;
    logic exp_t;
    ir_in = 1'b0;
    rd_data = 32'h12345678;
    prev = 1'b0;
    first_b = 1'b0;
    clr_states();
    cdr = 1; tick(); cdr = 0;
    sdr = 1;
    for (int i = 0; i < DW; i++) begin
      b = 1'($urandom_range(0, 1));
      if (i == 0) first_b = b;
`ifdef VJTAG_READBACK_EN
      exp_t = rd_data[i];
`else
      exp_t = prev;
`endif
      vectors++;
      if (tdo !== exp_t) begin
        miscompares++;
        $display("FAIL read_tdo[%0d]: got %b, want %b", i, tdo, exp_t);
      end
      tdi = b; prev = b;
      tick();
    end
    sdr = 0; tdi = 1'b0;
    udr = 1; tick(); udr = 0;
    cir = 1; tick(); cir = 0;
`ifdef VJTAG_READBACK_EN
    exp_t = first_b;
`else
    exp_t = prev;
`endif
    vectors++;
    if (wr_valid !== 1'b0 || overflow !== 1'b0 || tdo !== exp_t) begin
      miscompares++;
      $display("FAIL read_update_hold: got wr_valid=%b overflow=%b tdo=%b, want 0 0 %b",
               wr_valid, overflow, tdo, exp_t);
    end
  endtask

  task automatic test_reset_mid();
    do_write(32'h000000A1, 1'b0);
    do_write(32'h000000A2, 1'b0);
    ir_in = 1'b1;
    clr_states();
    cdr = 1; tick(); cdr = 0;
    sdr = 1; tdi = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (wr_valid !== 1'b0 || tdo !== 1'b0 || overflow !== 1'b0 || ir_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got wr_valid=%b tdo=%b overflow=%b ir_out=%b, want all 0",
               wr_valid, tdo, overflow, ir_out);
    end
    exp_q.delete();
    exp_ovf = 1'b0;
    clr_states();
    tdi = 1'b0;
    @(negedge tck);
    rst = 1'b0;
    tick();
    do_write(32'h5A5AC3C3, 1'b0);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_uir();
    test_full_pop();
    test_readback();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
